priv_1_12_trap_sequencer: RTL
=============================

# priv_1_12_trap_sequencer

Multi-cycle sequencer that owns every privileged control-flow change in the 1.12 privilege unit: synchronous exceptions, machine interrupts, `mret` and `sret`. It arbitrates among these events at the commit boundary and latches the winner. It then drives a flush/drain handshake with the pipeline, issues one-cycle CSR update strobes, and holds the redirect PC until fetch accepts it. It sits between the commit stage, the CSR file and the fetch-stage PC mux, and replaces single-cycle combinational redirect generation.

## Interface
Parameters: none.
- `CLK` in 1: clock, rising edge.
- `nRST` in 1: reset, asynchronous, active-low.
- `exc_valid` in 1: committing instruction raised an exception.
- `exc_cause` in 5: exception code.
- `exc_tval` in 32: trap value for the exception.
- `epc_in` in 32: PC of the committing instruction.
- `mret`, `sret` in 1 each: committing instruction is a return.
- `irq_pending` in 16: `mip & mie`; bit n is cause n.
- `mstatus_mie` in 1: global machine interrupt enable.
- `mtvec` in 32: `[31:2]` base, `[1:0]` mode.
- `mepc`, `sepc` in 32 each: current return addresses.
- `pipe_drained` in 1: pipeline empty and flush complete.
- `fetch_ack` in 1: fetch has taken `priv_pc`.
- `busy` out 1: state is not IDLE. Upstream stalls commit while high.
- `flush_req` out 1: request pipeline flush.
- `csr_trap_we` out 1: write `next_mcause`, `next_mepc` and `next_mtval`; push `mstatus`.
- `csr_mret_we`, `csr_sret_we` out 1 each: pop `mstatus` for the respective return.
- `next_mcause` out 32: `[31]` interrupt flag, `[4:0]` code, all other bits 0.
- `next_mepc`, `next_mtval` out 32 each.
- `insert_pc` out 1: redirect valid.
- `priv_pc` out 32: redirect target.

## Operation
- **Reset:** all outputs are 0 and the state is IDLE. Assertion mid-sequence returns immediately to IDLE, drops any latched event and issues no CSR strobe.
- **Event sampling:** events are sampled only in IDLE. Inputs arriving in any other state are ignored.
- **Event priority:** exception > interrupt > `mret` > `sret`.
- **Interrupt eligibility:** an interrupt is eligible iff `mstatus_mie` = 1 and `irq_pending` ≠ 0.
- **Interrupt source priority:** 11 > 3 > 7 > 9 > 1 > 5. Any remaining set bit is chosen lowest-index-first.
- **Latching a trap:** the winner's cause, `epc_in`, tval and target are latched. Tval is `exc_tval` for an exception and 0 for an interrupt.
- **Trap target:**
  - Base is `{mtvec[31:2],2'b00}`.
  - If mode = 1 and the event is an interrupt, the target is base + (code << 2), truncated to 32 bits.
  - Otherwise, including reserved modes 2 and 3, the target is base.
- **Return targets:** `mret` uses `mepc`; `sret` uses `sepc`. Both are sampled at acceptance.
- **FSM:**
  - **IDLE:** if an event wins, latch it and go to FLUSH.
  - **FLUSH:** `flush_req` = 1. If `pipe_drained`, go to UPDATE.
  - **UPDATE:** exactly one cycle. Assert the single strobe matching the event type. `next_*` outputs are valid this cycle.
  - **REDIRECT:** `insert_pc` = 1 and `priv_pc` holds the target. If `fetch_ack`, go to IDLE.
- **Output stability:** `next_*` and `priv_pc` hold their latched values from UPDATE until IDLE is re-entered, then clear to 0.

## Timing
- **Acceptance:** the event is presented in cycle 0 while in IDLE. `busy` and `flush_req` go high in cycle 1.
- **Drain:** if `pipe_drained` is 1 in cycle 1, UPDATE occurs in cycle 2 and `insert_pc` first rises in cycle 3. Minimum latency is 3 cycles.
- **Stall tolerance:** every extra cycle without `pipe_drained` or `fetch_ack` adds exactly one cycle. There is no timeout.
- **Early `pipe_drained`:** `pipe_drained` asserted while in IDLE has no effect.
- **Early `fetch_ack`:** `fetch_ack` asserted before REDIRECT is ignored.
- **Return to IDLE:** `fetch_ack` in REDIRECT cycle k gives IDLE in cycle k+1, and a new event may be accepted in k+1.
- **Simultaneous events:** if `exc_valid` and `mret` are both high, an exception trap is taken and `csr_mret_we` never asserts.

## Test plan
- **Direct exception:** `exc_valid`, cause 2, `epc_in`=0x100, `exc_tval`=0xDEAD, `mtvec`=0x8000_0001, `pipe_drained` tied 1, `fetch_ack` tied 1 → flush cycle 1; UPDATE cycle 2 with `next_mcause`=0x2, `next_mepc`=0x100, `next_mtval`=0xDEAD; `insert_pc` cycle 3 with `priv_pc`=0x8000_0000.
- **Vectored interrupt:** `irq_pending`=0x0880, `mstatus_mie`=1, `mtvec`=0x8000_0001 → source 11 wins; `next_mcause`=0x8000_000B; `priv_pc`=0x8000_002C.
- **Interrupt masked:** same interrupt stimulus with `mstatus_mie`=0 plus `mret`, `mepc`=0x200 → `csr_mret_we` one cycle, `priv_pc`=0x200, `csr_trap_we` never asserts.
- **Handshake stall:** `pipe_drained` held low 4 cycles and `fetch_ack` low 2 cycles → `flush_req` high 5 cycles and `insert_pc` high 3 cycles; a new `exc_valid` during this window is ignored.
- **Reset mid-sequence:** `nRST` asserted during FLUSH → all outputs 0 immediately; after release with no event, no strobe ever fires.
- **Priority collision:** `exc_valid` and `sret` together → exception trap taken; `csr_sret_we` stays 0.

Source files
------------

// File: rtl/priv_1_12_trap_sequencer.sv
// Privileged control-flow sequencer: arbitrates exceptions, interrupts, mret and sret at commit,
// then walks flush -> CSR update -> redirect, holding the redirect PC until fetch accepts it.
module priv_1_12_trap_sequencer (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        exc_valid,
    input  logic [4:0]  exc_cause,
    input  logic [31:0] exc_tval,
    input  logic [31:0] epc_in,
    input  logic        mret,
    input  logic        sret,
    input  logic [15:0] irq_pending,
    input  logic        mstatus_mie,
    input  logic [31:0] mtvec,
    input  logic [31:0] mepc,
    input  logic [31:0] sepc,
    input  logic        pipe_drained,
    input  logic        fetch_ack,
    output logic        busy,
    output logic        flush_req,
    output logic        csr_trap_we,
    output logic        csr_mret_we,
    output logic        csr_sret_we,
    output logic [31:0] next_mcause,
    output logic [31:0] next_mepc,
    output logic [31:0] next_mtval,
    output logic        insert_pc,
    output logic [31:0] priv_pc
);

    typedef enum logic [1:0] {IDLE, FLUSH, UPDATE, REDIRECT} state_t;
    typedef enum logic [1:0] {EV_NONE, EV_TRAP, EV_MRET, EV_SRET} event_t;

    state_t      state, state_next;
    event_t      ev_sel, ev_q;
    logic [3:0]  irq_code;
    logic        irq_eligible;
    logic [31:0] trap_base;
    logic        sel_irq;
    logic [4:0]  sel_cause;
    logic [31:0] sel_tval, sel_target;
    logic        irq_q;
    logic [4:0]  cause_q;
    logic [31:0] epc_q, tval_q, target_q;
    logic        hold;

    // Lowest set bit first, then the fixed-priority sources override in ascending priority order
    always_comb begin
        irq_code = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (irq_pending[i]) irq_code = i[3:0];
        end
        if (irq_pending[5])  irq_code = 4'd5;
        if (irq_pending[1])  irq_code = 4'd1;
        if (irq_pending[9])  irq_code = 4'd9;
        if (irq_pending[7])  irq_code = 4'd7;
        if (irq_pending[3])  irq_code = 4'd3;
        if (irq_pending[11]) irq_code = 4'd11;
    end

    assign irq_eligible = mstatus_mie && (irq_pending != 16'd0);
    assign trap_base    = {mtvec[31:2], 2'b00};

    always_comb begin
        ev_sel     = EV_NONE;
        sel_irq    = 1'b0;
        sel_cause  = 5'd0;
        sel_tval   = 32'd0;
        sel_target = 32'd0;
        if (exc_valid) begin
            ev_sel     = EV_TRAP;
            sel_cause  = exc_cause;
            sel_tval   = exc_tval;
            sel_target = trap_base;
        end else if (irq_eligible) begin
            ev_sel     = EV_TRAP;
            sel_irq    = 1'b1;
            sel_cause  = {1'b0, irq_code};
            sel_target = (mtvec[1:0] == 2'b01) ? trap_base + {26'd0, irq_code, 2'b00} : trap_base;
        end else if (mret) begin
            ev_sel     = EV_MRET;
            sel_target = mepc;
        end else if (sret) begin
            ev_sel     = EV_SRET;
            sel_target = sepc;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            ev_q     <= EV_NONE;
            irq_q    <= 1'b0;
            cause_q  <= 5'd0;
            epc_q    <= 32'd0;
            tval_q   <= 32'd0;
            target_q <= 32'd0;
        end else begin
            state <= state_next;
            if (state == IDLE && ev_sel != EV_NONE) begin
                ev_q     <= ev_sel;
                irq_q    <= sel_irq;
                cause_q  <= sel_cause;
                epc_q    <= (ev_sel == EV_TRAP) ? epc_in : 32'd0;
                tval_q   <= sel_tval;
                target_q <= sel_target;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (ev_sel != EV_NONE) state_next = FLUSH;
            FLUSH:    if (pipe_drained) state_next = UPDATE;
            UPDATE:   state_next = REDIRECT;
            REDIRECT: if (fetch_ack) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    // Latched results stay visible from UPDATE through REDIRECT and read as zero otherwise
    always_comb begin
        hold        = (state == UPDATE) || (state == REDIRECT);
        busy        = (state != IDLE);
        flush_req   = (state == FLUSH);
        insert_pc   = (state == REDIRECT);
        csr_trap_we = (state == UPDATE) && (ev_q == EV_TRAP);
        csr_mret_we = (state == UPDATE) && (ev_q == EV_MRET);
        csr_sret_we = (state == UPDATE) && (ev_q == EV_SRET);
        next_mcause = 32'd0;
        next_mepc   = 32'd0;
        next_mtval  = 32'd0;
        priv_pc     = 32'd0;
        if (hold) begin
            priv_pc = target_q;
            if (ev_q == EV_TRAP) begin
                next_mcause = {irq_q, 26'd0, cause_q};
                next_mepc   = epc_q;
                next_mtval  = tval_q;
            end
        end
    end

endmodule
